// File: rtl/clock_div_burst.sv
// Programmable integer clock divider with selectable idle polarity, edge strobes,
// N-period bursts or free-run with graceful stop. Ratio updates only at period boundaries.
module clock_div_burst #(
  parameter int DLY    = 1,
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              gen_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [WIDTH-1:0]  period_i,
  input  logic [CWIDTH-1:0] cycles_i,
  input  logic              cpol_i,
  output logic              clk_o,
  output logic              lead_o,
  output logic              trail_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [WIDTH-1:0]  PER_MIN  = WIDTH'(2);
  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
  localparam logic [CWIDTH-1:0] REM_ONE  = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] REM_ZERO = '0;

  // DLY is kept for drop-in compatibility with the older divider; this RTL carries no delays.
  if (DLY < 0) begin : g_dly_unused
  end

  logic [0:0]        state_r, state_s;
  logic [WIDTH-1:0]  cnt_r, cnt_s;
  logic [WIDTH-1:0]  per_r, per_s;
  logic [CWIDTH-1:0] rem_r, rem_s;
  logic              cpol_r, cpol_s;
  logic              stop_pend_r, stop_pend_s;
  logic              clk_s, lead_s, trail_s, busy_s, done_s;

  logic [WIDTH-1:0]  per_clamp_s;
  logic [WIDTH-1:0]  half_s;
  logic              at_half_s;
  logic              at_end_s;
  logic              finish_s;

  // Ratio clamp, half-period split (active phase gets the extra cycle for odd N) and phase markers
  always_comb begin
    if (period_i < PER_MIN) begin
      per_clamp_s = PER_MIN;
    end else begin
      per_clamp_s = period_i;
    end
    half_s    = per_r - (per_r >> 1);
    at_half_s = (cnt_r == (half_s - CNT_ONE));
    at_end_s  = (cnt_r == (per_r - CNT_ONE));
    finish_s  = stop_pend_r | stop_i | (rem_r == REM_ONE);
  end

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    per_s       = per_r;
    rem_s       = rem_r;
    cpol_s      = cpol_r;
    stop_pend_s = stop_pend_r;
    clk_s       = clk_o;
    lead_s      = 1'b0;
    trail_s     = 1'b0;
    busy_s      = busy_o;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (start_i) begin
          state_s     = ST_RUN;
          cnt_s       = '0;
          per_s       = per_clamp_s;
          rem_s       = cycles_i;
          cpol_s      = cpol_i;
          stop_pend_s = 1'b0;
          clk_s       = ~cpol_i;
          lead_s      = 1'b1;
          busy_s      = 1'b1;
        end else begin
          cpol_s = cpol_i;
          clk_s  = cpol_i;
        end
      end
      ST_RUN: begin
        busy_s = 1'b1;
        if (!gen_i) begin
          stop_pend_s = stop_pend_r | stop_i;
        end else if (at_end_s) begin
          if (finish_s) begin
            state_s     = ST_IDLE;
            busy_s      = 1'b0;
            done_s      = 1'b1;
            clk_s       = cpol_r;
            stop_pend_s = 1'b0;
          end else begin
            cnt_s  = '0;
            per_s  = per_clamp_s;
            clk_s  = ~cpol_r;
            lead_s = 1'b1;
            // rem of zero means free-run and must never wrap
            if (rem_r != REM_ZERO) begin
              rem_s = rem_r - REM_ONE;
            end else begin
              rem_s = rem_r;
            end
          end
        end else if (at_half_s) begin
          cnt_s       = half_s;
          clk_s       = cpol_r;
          trail_s     = 1'b1;
          stop_pend_s = stop_pend_r | stop_i;
        end else begin
          cnt_s       = cnt_r + CNT_ONE;
          stop_pend_s = stop_pend_r | stop_i;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        clk_s   = cpol_r;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      per_r       <= PER_MIN;
      rem_r       <= '0;
      cpol_r      <= 1'b0;
      stop_pend_r <= 1'b0;
      clk_o       <= 1'b0;
      lead_o      <= 1'b0;
      trail_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      per_r       <= per_s;
      rem_r       <= rem_s;
      cpol_r      <= cpol_s;
      stop_pend_r <= stop_pend_s;
      clk_o       <= clk_s;
      lead_o      <= lead_s;
      trail_o     <= trail_s;
      busy_o      <= busy_s;
      done_o      <= done_s;
    end
  end

endmodule

// File: tb/tb_clock_div_burst.sv
// Scoreboard bench for clock_div_burst: directed per-cycle tables push expected
// {clk_o,lead_o,trail_o,busy_o,done_o}; a monitor pops and compares after every edge.
module tb_clock_div_burst;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        gen_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [7:0]  period_i = 8'd4;
  logic [15:0] cycles_i = 16'd0;
  logic        cpol_i = 1'b0;
  logic        clk_o, lead_o, trail_o, busy_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] tag;
    int          idx;
    logic [4:0]  val;
  } exp_t;

  exp_t exp_q[$];

  clock_div_burst #(.DLY(1), .WIDTH(8), .CWIDTH(16)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .gen_i   (gen_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .period_i(period_i),
    .cycles_i(cycles_i),
    .cpol_i  (cpol_i),
    .clk_o   (clk_o),
    .lead_o  (lead_o),
    .trail_o (trail_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Empty table string means "every cycle at the default level".
  function automatic logic chr(input string s, input int i, input logic dflt);
    if (s.len() == 0) return dflt;
    return (s[i] == 8'h31);
  endfunction

  // Cycle i: inputs driven before edge i, expectation is the output state after edge i.
  task automatic seq(input logic [63:0] tag, input int per, input int cyc, input logic cp,
                     input string rs, input string st, input string sp, input string gn,
                     input string e_clk, input string e_lead, input string e_trail,
                     input string e_busy, input string e_done);
    exp_t e;
    for (int i = 0; i < e_clk.len(); i++) begin
      @(negedge clk_i);
      period_i = per[7:0];
      cycles_i = cyc[15:0];
      cpol_i   = cp;
      rst_n_i  = chr(rs, i, 1'b1);
      start_i  = chr(st, i, 1'b0);
      stop_i   = chr(sp, i, 1'b0);
      gen_i    = chr(gn, i, 1'b1);
      e.tag = tag;
      e.idx = i;
      e.val = {chr(e_clk, i, 1'b0), chr(e_lead, i, 1'b0), chr(e_trail, i, 1'b0),
               chr(e_busy, i, 1'b0), chr(e_done, i, 1'b0)};
      exp_q.push_back(e);
    end
  endtask

  // Monitor: outputs are registered every cycle, so each edge presents one response.
  always @(posedge clk_i) begin
    exp_t e;
    logic [4:0] got;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {clk_o, lead_o, trail_o, busy_o, done_o};
      n_tests++;
      if (got !== e.val) begin
        n_fail++;
        $display("FAIL %s cycle %0d: clk/lead/trail/busy/done got %b required %b",
                 e.tag, e.idx, got, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    seq("reset", 4, 10, 1'b0, "00", "00", "", "",
        "00", "00", "00", "00", "00");
    // cpol=0, N=4, 3 periods
    seq("burst_c0", 4, 3, 1'b0, "", "10000000000000", "", "",
        "11001100110000", "10001000100000", "00100010001000",
        "11111111111100", "00000000000010");
    // cpol=1, N=5: low 3, high 2
    seq("cpol1_n5", 5, 2, 1'b1, "", "100000000000", "", "",
        "000110001111", "100001000000", "000100001000",
        "111111111100", "000000000010");
    seq("per0_n2", 0, 2, 1'b1, "", "100000", "", "",
        "010111", "101000", "010100", "111100", "000010");
    seq("per1_n2", 1, 1, 1'b1, "", "1000", "", "",
        "0111", "1000", "0100", "1100", "0010");
    // free-run N=6, ratio changed to 2 mid-period, back to 6, then stop mid-period
    seq("free_a", 6, 0, 1'b0, "", "10", "", "",
        "11", "10", "00", "11", "00");
    seq("free_b", 2, 0, 1'b0, "", "000000", "", "",
        "100010", "000010", "010001", "111111", "000000");
    seq("free_c", 6, 0, 1'b0, "", "00000000", "01000000", "",
        "11100000", "10000000", "00010000", "11111100", "00000010");
    // gen_i low for 5 cycles inside the active phase
    seq("gen_hold", 4, 1, 1'b0, "", "10000000000", "", "10000011111",
        "11111110000", "10000000000", "00000001000",
        "11111111100", "00000000010");
    // start+stop together in IDLE, then start pulses during RUN
    seq("st_sp", 2, 2, 1'b0, "", "111000", "100000", "",
        "101000", "101000", "010100", "111100", "000010");
    // reset after 3 periods of a 10-period burst
    seq("rst_mid", 4, 10, 1'b1, "111111111111011", "100000000000000", "", "",
        "001100110011011", "100010001000000", "001000100010000",
        "111111111111000", "000000000000000");
    repeat (3) @(negedge clk_i);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
